cache_line_fill: RTL and testbench
==================================

Name: cache_line_fill

Overview:
- Back-end line-fill controller for iob-cache.
- On a read miss, latches the victim way chosen by the replacement policy and fetches the whole line from back-end memory over the native valid/ready interface.
- Writes each word into that way's data memory, then commits tag/valid.
- Drives the replacement-policy update (write_en/way_hit) so the filled way becomes most recently used.

Parameters:
- FE_ADDR_W, 32, front-end byte address width
- BE_DATA_W, 32, back-end word width (one word per handshake)
- N_WAYS, 8, number of ways
- NWAY_W, $clog2(N_WAYS), way index width
- LINE_OFF_W, 7, line index width
- WORD_OFF_W, 3, log2(words per line)
- BYTE_W, $clog2(BE_DATA_W/8), byte offset width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- fill_req  in  1  start fill (sampled in IDLE only)
- fill_addr  in  FE_ADDR_W  missed byte address
- fill_way  in  N_WAYS  one-hot victim way (from replacement policy way_select)
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle completion pulse
- fill_crit_valid  out  1  requested word written (see Optional Feature)
- mem_valid  out  1  back-end request
- mem_addr  out  FE_ADDR_W  back-end word address, byte offset bits zero
- mem_ready  in  1  back-end accept/data-valid
- mem_rdata  in  BE_DATA_W  back-end read data
- line_wr_en  out  1  data memory write strobe
- line_wr_way  out  N_WAYS  one-hot way
- line_wr_index  out  LINE_OFF_W  line index
- line_wr_word  out  WORD_OFF_W  word offset in line
- line_wr_data  out  BE_DATA_W  data (= mem_rdata)
- tag_wr_en  out  1  tag/valid write strobe (index/way as line_wr_*)
- repl_write_en  out  1  replacement-policy write_en
- repl_way_hit  out  N_WAYS  replacement-policy way_hit (= latched way when repl_write_en, else 0)

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-fill aborts immediately; mem_valid drops asynchronously; partial line is left without a tag write.
- States:
  - IDLE: fill_busy=0. If fill_req, latch fill_way, index = fill_addr[BYTE_W+WORD_OFF_W +: LINE_OFF_W], tag bits and start word; go to FETCH next cycle.
  - FETCH: fill_busy=1, mem_valid=1 held until mem_ready. mem_addr = {fill_addr[FE_ADDR_W-1:BYTE_W+WORD_OFF_W], word_cnt, BYTE_W'b0}. Each cycle with mem_ready: line_wr_en=1 combinationally in the same cycle, line_wr_word=word_cnt, line_wr_data=mem_rdata, and word_cnt increments modulo 2^WORD_OFF_W. After 2^WORD_OFF_W accepted words, go to COMMIT.
  - COMMIT: one cycle; tag_wr_en=1, repl_write_en=1, repl_way_hit=latched way, fill_done=1, fill_busy=1. Go to IDLE.
- Latency: fill_req accepted at cycle 0. Zero-wait back-end gives words at cycles 1..2^WORD_OFF_W and fill_done at cycle 2^WORD_OFF_W+1. The earliest next accept is the following cycle.
- mem_valid never drops before mem_ready and never glitches between words; address changes only after a handshake.
- fill_req while busy (including the COMMIT cycle) is ignored, not queued.
- fill_way is used verbatim. A non-one-hot fill_way is a protocol error and triggers a bench assertion; the block does not correct it.
- Inputs fill_addr and fill_way are sampled only on acceptance; later changes have no effect.

Optional Feature:
- IOB_CACHE_CRITICAL_WORD_FIRST_EN
- Defined:
  - Fetch starts at word offset fill_addr[BYTE_W +: WORD_OFF_W] and wraps modulo line size.
  - fill_crit_valid pulses for one cycle with the first (requested-word) write, enabling early restart of the front end.
  - Completion still requires all 2^WORD_OFF_W words.
- Undefined: fetch starts at word 0; fill_crit_valid tied 0.

Decomposition:
- Shared package iob_cache_fill_pkg holds:
  - state encoding (IDLE=2'd0, FETCH=2'd1, COMMIT=2'd2)
  - BYTE_W derivation
  - words-per-line constant
- One natural sub-module, line_fill_counter: a WORD_OFF_W-bit load/increment wrap counter plus a separate done counter, with load value, enable and last-word flag.

Test Plan:
- N_WAYS=8, WORD_OFF_W=2, fill_addr=0x0000_1234, fill_way=8'b0010_0000, zero-wait memory -> mem_addr 0x1230,0x1234,0x1238,0x123C (0x1234 first with macro). line_wr_way=way 5 and line_wr_index=0x23 on 4 writes. fill_done at cycle 5 with repl_way_hit=8'b0010_0000.
- Back-end stalls 3 cycles per word -> mem_valid stays high and mem_addr stays stable during the stall. Exactly 4 line_wr_en pulses. fill_done at cycle 13.
- fill_req held high continuously -> second fill accepted in the cycle after fill_done. No request is lost or duplicated.
- Reset asserted after 2nd word -> mem_valid=0 immediately, no tag_wr_en/repl_write_en, next fill starts cleanly from IDLE.
- fill_addr/fill_way changed during FETCH -> no effect on mem_addr or line_wr_way.
- With IOB_CACHE_CRITICAL_WORD_FIRST_EN and fill_addr=0x...C -> order words 3,0,1,2; fill_crit_valid coincides with the first line_wr_en only.

Source files
------------

// File: rtl/iob_cache_fill_pkg.sv
// rtl/iob_cache_fill_pkg.sv - shared state encoding and geometry helpers for the line-fill controller
package iob_cache_fill_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    COMMIT = 2'd2
  } fill_state_t;

  function automatic int byte_w(input int be_data_w);
    return $clog2(be_data_w / 8);
  endfunction

  function automatic int words_per_line(input int word_off_w);
    return 1 << word_off_w;
  endfunction

endpackage

// File: rtl/line_fill_counter.sv
// rtl/line_fill_counter.sv - wrapping word-offset counter plus accepted-word counter for one line fill
module line_fill_counter
  import iob_cache_fill_pkg::*;
#(
  parameter int WORD_OFF_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WORD_OFF_W-1:0] load_val,
  input  logic                  en,
  output logic [WORD_OFF_W-1:0] word_cnt,
  output logic                  first,
  output logic                  last
);

  localparam int WORDS = words_per_line(WORD_OFF_W);

  // word_cnt addresses memory and may start mid-line; done_cnt always counts from zero
  logic [WORD_OFF_W-1:0] done_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt <= '0;
      done_cnt <= '0;
    end else if (load) begin
      word_cnt <= load_val;
      done_cnt <= '0;
    end else if (en) begin
      word_cnt <= word_cnt + 1'b1;
      done_cnt <= done_cnt + 1'b1;
    end
  end

  assign first = (done_cnt == '0);
  assign last  = (done_cnt == WORD_OFF_W'(WORDS - 1));

endmodule

// File: rtl/cache_line_fill.sv
// rtl/cache_line_fill.sv - iob-cache back-end line-fill controller (victim way fill, tag commit, LRU update)
// Optional IOB_CACHE_CRITICAL_WORD_FIRST_EN: fetch starts at the requested word and wraps.
module cache_line_fill
  import iob_cache_fill_pkg::*;
#(
  parameter int FE_ADDR_W  = 32,
  parameter int BE_DATA_W  = 32,
  parameter int N_WAYS     = 8,
  parameter int NWAY_W     = $clog2(N_WAYS),
  parameter int LINE_OFF_W = 7,
  parameter int WORD_OFF_W = 3,
  parameter int BYTE_W     = byte_w(BE_DATA_W)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fill_req,
  input  logic [FE_ADDR_W-1:0]  fill_addr,
  input  logic [N_WAYS-1:0]     fill_way,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  fill_crit_valid,
  output logic                  mem_valid,
  output logic [FE_ADDR_W-1:0]  mem_addr,
  input  logic                  mem_ready,
  input  logic [BE_DATA_W-1:0]  mem_rdata,
  output logic                  line_wr_en,
  output logic [N_WAYS-1:0]     line_wr_way,
  output logic [LINE_OFF_W-1:0] line_wr_index,
  output logic [WORD_OFF_W-1:0] line_wr_word,
  output logic [BE_DATA_W-1:0]  line_wr_data,
  output logic                  tag_wr_en,
  output logic                  repl_write_en,
  output logic [N_WAYS-1:0]     repl_way_hit
);

`ifdef IOB_CACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CRIT_FIRST = 1'b1;
`else
  localparam bit CRIT_FIRST = 1'b0;
`endif

  // tag and index bits of the missed line, kept together as the line's base address
  localparam int LINE_ADDR_W = FE_ADDR_W - BYTE_W - WORD_OFF_W;

  fill_state_t state, state_nxt;

  logic [N_WAYS-1:0]      way_q;
  logic [LINE_ADDR_W-1:0] line_addr_q;
  logic [WORD_OFF_W-1:0]  word_cnt;
  logic [WORD_OFF_W-1:0]  start_word;
  logic                   accept;
  logic                   beat;
  logic                   first_word;
  logic                   last_word;

  assign accept     = (state == IDLE) && fill_req;
  assign beat       = (state == FETCH) && mem_ready;
  assign start_word = CRIT_FIRST ? fill_addr[BYTE_W +: WORD_OFF_W] : '0;

  line_fill_counter #(
    .WORD_OFF_W(WORD_OFF_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (start_word),
    .en       (beat),
    .word_cnt (word_cnt),
    .first    (first_word),
    .last     (last_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      way_q       <= '0;
      line_addr_q <= '0;
    end else if (accept) begin
      way_q       <= fill_way;
      line_addr_q <= fill_addr[FE_ADDR_W-1:BYTE_W+WORD_OFF_W];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fill_req) state_nxt = FETCH;
      FETCH:   if (mem_ready && last_word) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fill_busy       = 1'b0;
    fill_done       = 1'b0;
    fill_crit_valid = 1'b0;
    mem_valid       = 1'b0;
    line_wr_en      = 1'b0;
    tag_wr_en       = 1'b0;
    repl_write_en   = 1'b0;
    repl_way_hit    = '0;
    mem_addr        = {line_addr_q, word_cnt, {BYTE_W{1'b0}}};
    line_wr_way     = way_q;
    line_wr_index   = line_addr_q[LINE_OFF_W-1:0];
    line_wr_word    = word_cnt;
    line_wr_data    = mem_rdata;
    case (state)
      FETCH: begin
        fill_busy       = 1'b1;
        mem_valid       = 1'b1;
        line_wr_en      = mem_ready;
        fill_crit_valid = mem_ready && CRIT_FIRST && first_word;
      end
      COMMIT: begin
        fill_busy     = 1'b1;
        fill_done     = 1'b1;
        tag_wr_en     = 1'b1;
        repl_write_en = 1'b1;
        repl_way_hit  = way_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_line_fill.sv
// tb/tb_cache_line_fill.sv - self-checking bench for cache_line_fill (WORD_OFF_W=2, 8 ways)
`timescale 1ns/1ps
module tb_cache_line_fill;

  localparam int FE_ADDR_W  = 32;
  localparam int BE_DATA_W  = 32;
  localparam int N_WAYS     = 8;
  localparam int LINE_OFF_W = 7;
  localparam int WORD_OFF_W = 2;
  localparam int WORDS      = 4;

`ifdef IOB_CACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  fill_req;
  logic [FE_ADDR_W-1:0]  fill_addr;
  logic [N_WAYS-1:0]     fill_way;
  logic                  fill_busy, fill_done, fill_crit_valid;
  logic                  mem_valid, mem_ready;
  logic [FE_ADDR_W-1:0]  mem_addr;
  logic [BE_DATA_W-1:0]  mem_rdata;
  logic                  line_wr_en, tag_wr_en, repl_write_en;
  logic [N_WAYS-1:0]     line_wr_way, repl_way_hit;
  logic [LINE_OFF_W-1:0] line_wr_index;
  logic [WORD_OFF_W-1:0] line_wr_word;
  logic [BE_DATA_W-1:0]  line_wr_data;

  cache_line_fill #(
    .FE_ADDR_W(FE_ADDR_W), .BE_DATA_W(BE_DATA_W), .N_WAYS(N_WAYS),
    .LINE_OFF_W(LINE_OFF_W), .WORD_OFF_W(WORD_OFF_W)
  ) dut (
    .clk(clk), .reset(reset), .fill_req(fill_req), .fill_addr(fill_addr), .fill_way(fill_way),
    .fill_busy(fill_busy), .fill_done(fill_done), .fill_crit_valid(fill_crit_valid),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .line_wr_en(line_wr_en), .line_wr_way(line_wr_way), .line_wr_index(line_wr_index),
    .line_wr_word(line_wr_word), .line_wr_data(line_wr_data), .tag_wr_en(tag_wr_en),
    .repl_write_en(repl_write_en), .repl_way_hit(repl_way_hit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stall = 0;

  // model of the fill in flight: timeline plus the expected beat sequence
  bit          m_act = 1'b0;
  int          m_t0, m_end;
  logic [7:0]  m_way;
  logic [6:0]  m_index;
  logic [31:0] q_addr[$];
  int          q_word[$];

  logic [31:0] log_addr[$];
  int          log_word[$];
  logic [7:0]  last_wr_way, last_hit;
  logic [6:0]  last_wr_index;
  int          n_done = 0, n_tag = 0, n_crit = 0, last_done_off = 0;
  int          acc_cyc[$];
  int          done_cyc[$];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // back-end: ready after `stall` idle cycles of each request
  initial begin
    int wc;
    wc = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_valid) begin
        if (wc >= stall) begin
          mem_ready = 1'b1;
          mem_rdata = data_of(mem_addr);
          wc = 0;
        end else begin
          mem_ready = 1'b0;
          wc++;
        end
      end else begin
        mem_ready = 1'b0;
        wc = 0;
      end
    end
  end

  // compare process: every cycle against the model
  initial begin
    bit e_busy, e_valid, e_done, e_wr;
    int start, w;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_busy", fill_busy, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_done", fill_done, 0);
        check("rst_wr_en", line_wr_en, 0);
        check("rst_tag_wr", tag_wr_en, 0);
        check("rst_repl_we", repl_write_en, 0);
        check("rst_way_hit", repl_way_hit, 0);
        check("rst_crit", fill_crit_valid, 0);
        m_act = 1'b0;
        q_addr.delete();
        q_word.delete();
      end else begin
        e_busy  = m_act && (cyc > m_t0) && (cyc <= m_end);
        e_valid = e_busy && (cyc < m_end);
        e_done  = e_busy && (cyc == m_end);
        e_wr    = e_valid && mem_ready;
        check("busy", fill_busy, e_busy);
        check("mem_valid", mem_valid, e_valid);
        check("fill_done", fill_done, e_done);
        check("tag_wr_en", tag_wr_en, e_done);
        check("repl_write_en", repl_write_en, e_done);
        check("repl_way_hit", repl_way_hit, e_done ? m_way : 8'h00);
        check("line_wr_en", line_wr_en, e_wr);
        check("crit_valid", fill_crit_valid, e_wr && CWF && (q_addr.size() == WORDS));
        if (tag_wr_en) n_tag++;
        if (e_valid && q_addr.size() > 0) check("mem_addr", mem_addr, q_addr[0]);
        if (e_wr && q_addr.size() > 0) begin
          check("wr_word", line_wr_word, q_word[0]);
          check("wr_way", line_wr_way, m_way);
          check("wr_index", line_wr_index, m_index);
          check("wr_data", line_wr_data, data_of(q_addr[0]));
          log_addr.push_back(mem_addr);
          log_word.push_back(int'(line_wr_word));
          last_wr_way = line_wr_way;
          last_wr_index = line_wr_index;
          if (fill_crit_valid) n_crit++;
          void'(q_addr.pop_front());
          void'(q_word.pop_front());
        end
        if (e_done) begin
          check("beats_left", q_addr.size(), 0);
          n_done++;
          done_cyc.push_back(cyc);
          last_done_off = cyc - m_t0;
          last_hit = repl_way_hit;
        end
        if (!e_busy && fill_req) begin
          assert ($onehot(fill_way)) else $error("protocol error: fill_way 0x%0h not one-hot", fill_way);
          m_act = 1'b1;
          m_t0 = cyc;
          m_end = cyc + WORDS * (stall + 1) + 1;
          m_way = fill_way;
          m_index = 7'((fill_addr >> 4) & 32'h7F);
          start = CWF ? int'((fill_addr >> 2) & 32'h3) : 0;
          q_addr.delete();
          q_word.delete();
          for (int i = 0; i < WORDS; i++) begin
            w = (start + i) % WORDS;
            q_word.push_back(w);
            q_addr.push_back((fill_addr & ~32'hF) | 32'(w * 4));
          end
          acc_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_word.delete();
    n_crit = 0;
  endtask

  task automatic start_fill(input logic [31:0] a, input logic [7:0] w);
    fill_addr = a;
    fill_way  = w;
    fill_req  = 1'b1;
    tick();
    fill_req  = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int k;
    k = 0;
    while (n_done < target && k < limit) begin
      tick();
      k++;
    end
    check("done_within_budget", n_done >= target, 1);
  endtask

  initial begin
    logic [31:0] exp_a[4];
    int d0, a0, tags0, dones0;
    reset = 1'b1;
    fill_req = 1'b0;
    fill_addr = '0;
    fill_way = '0;
    repeat (3) tick();
    check("reset_busy", fill_busy, 0);
    check("reset_mem_valid", mem_valid, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_way_hit", repl_way_hit, 0);
    reset = 1'b0;
    tick();

    // zero-wait fill of way 5
    stall = 0;
    clear_logs();
    start_fill(32'h0000_1234, 8'b0010_0000);
    wait_done(1, 50);
    if (CWF) exp_a = '{32'h1234, 32'h1238, 32'h123C, 32'h1230};
    else     exp_a = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
    check("t1_beats", log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) check($sformatf("t1_addr%0d", i), log_addr[i], exp_a[i]);
    check("t1_index", last_wr_index, 7'h23);
    check("t1_way", last_wr_way, 8'b0010_0000);
    check("t1_done_cycle", last_done_off, 5);
    check("t1_way_hit", last_hit, 8'b0010_0000);

    // three cycles per word
    stall = 2;
    clear_logs();
    start_fill(32'h0000_ABC8, 8'h04);
    wait_done(2, 100);
    check("t2_beats", log_addr.size(), 4);
    check("t2_done_cycle", last_done_off, 13);
    stall = 0;

    // request held high across two fills
    clear_logs();
    d0 = done_cyc.size();
    a0 = acc_cyc.size();
    fill_addr = 32'h2000_0040;
    fill_way = 8'h01;
    fill_req = 1'b1;
    wait_done(n_done + 2, 100);
    fill_req = 1'b0;
    check("t3_accepts", acc_cyc.size() - a0, 2);
    check("t3_beats", log_addr.size(), 8);
    if (done_cyc.size() > d0 && acc_cyc.size() > a0 + 1)
      check("t3_reaccept_gap", acc_cyc[a0 + 1] - done_cyc[d0], 1);
    repeat (2) tick();
    check("t3_no_extra", acc_cyc.size() - a0, 2);

    // reset after the second word
    clear_logs();
    start_fill(32'h0000_3300, 8'h10);
    for (int k = 0; k < 20 && log_addr.size() < 2; k++) tick();
    #1;
    reset = 1'b1;
    tags0 = n_tag;
    dones0 = n_done;
    #1;
    check("t4_mem_valid_drop", mem_valid, 0);
    check("t4_busy_drop", fill_busy, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("t4_no_tag", n_tag - tags0, 0);
    check("t4_no_done", n_done - dones0, 0);
    clear_logs();
    start_fill(32'h0000_0570, 8'h02);
    wait_done(dones0 + 1, 50);
    check("t4_clean_beats", log_addr.size(), 4);
    check("t4_clean_done", last_done_off, 5);
    if (log_addr.size() > 0) check("t4_clean_first", log_addr[0], 32'h0570);

    // inputs change during FETCH
    clear_logs();
    start_fill(32'h0001_8F64, 8'h80);
    fill_addr = 32'hFFFF_FFFF;
    fill_way = 8'h01;
    wait_done(n_done + 1, 50);
    if (log_addr.size() > 0) check("t5_first_addr", log_addr[0], CWF ? 32'h0001_8F64 : 32'h0001_8F60);
    check("t5_way", last_wr_way, 8'h80);
    check("t5_index", last_wr_index, 7'h76);
    check("t5_way_hit", last_hit, 8'h80);

    // word order for a request at the last word of the line
    clear_logs();
    start_fill(32'h0000_567C, 8'h08);
    wait_done(n_done + 1, 50);
    check("t6_beats", log_word.size(), 4);
    for (int i = 0; i < 4 && i < log_word.size(); i++)
      check($sformatf("t6_word%0d", i), log_word[i], CWF ? (i + 3) % 4 : i);
    check("t6_crit_pulses", n_crit, CWF ? 1 : 0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
